// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with a double-buffered display
// value, frame-synchronous updates and optional leading-zero blanking.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] data,
   input  logic        load,
   input  logic        blank_lz,
   output logic [7:0]  SEG,
   output logic [7:0]  AN,
   output logic        frame_done
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div;
   logic [2:0]       idx;
   logic [31:0]      shadow;
   logic [31:0]      disp;
   logic             pending;

   logic             tc;
   logic             frame_edge;
   logic [3:0]       nib;
   logic [7:0]       seg_dec;
   logic [7:0]       upper_nz;
   logic             blank;

   assign tc         = (div == DIV_LAST);
   assign frame_edge = tc && (idx == 3'd7);

   // upper_nz[i] is set when any of nibbles i..7 of disp is non-zero
   always_comb begin
      upper_nz = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         upper_nz[i] = |(disp >> (4 * i));
      end
   end

   always_comb begin
      nib   = disp[{idx, 2'b00} +: 4];
      blank = blank_lz && (idx != 3'd0) && !upper_nz[idx];
   end

   always_comb begin
      seg_dec = 8'hFF;
      case (nib)
         4'h0: seg_dec = 8'hC0;
         4'h1: seg_dec = 8'hF9;
         4'h2: seg_dec = 8'hA4;
         4'h3: seg_dec = 8'hB0;
         4'h4: seg_dec = 8'h99;
         4'h5: seg_dec = 8'h92;
         4'h6: seg_dec = 8'h82;
         4'h7: seg_dec = 8'hF8;
         4'h8: seg_dec = 8'h80;
         4'h9: seg_dec = 8'h90;
         4'hA: seg_dec = 8'h88;
         4'hB: seg_dec = 8'h83;
         4'hC: seg_dec = 8'hC6;
         4'hD: seg_dec = 8'hA1;
         4'hE: seg_dec = 8'h86;
         4'hF: seg_dec = 8'h8E;
         default: seg_dec = 8'hFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         div        <= '0;
         idx        <= '0;
         shadow     <= '0;
         disp       <= '0;
         pending    <= 1'b0;
         SEG        <= '1;
         AN         <= '1;
         frame_done <= 1'b0;
      end else begin
         if (tc) begin
            div <= '0;
            idx <= idx + 3'd1;
         end else begin
            div <= div + DIV_W'(1);
         end

         if (load) begin
            shadow <= data;
         end

         // A load on the boundary edge re-arms pending for the following frame
         if (frame_edge && pending) begin
            disp <= shadow;
         end
         if (load) begin
            pending <= 1'b1;
         end else if (frame_edge) begin
            pending <= 1'b0;
         end

         frame_done <= frame_edge;

         if (blank) begin
            SEG <= '1;
            AN  <= '1;
         end else begin
            SEG <= seg_dec;
            AN  <= ~(8'd1 << idx);
         end
      end
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles each digit stays lit; legal range 2..2^24.
REQ-002 clk  input  1  system clock; every register updates on its rising edge.
REQ-003 clr  input  1  reset, synchronous and active-high.
REQ-004 data  input  32  value to display; nibble i drives digit i, with digit 0 the rightmost.
REQ-005 load  input  1  while high, data is captured into the shadow register on that edge.
REQ-006 blank_lz  input  1  enables leading-zero blanking.
REQ-007 SEG  output  8  active-low segments: SEG[6:0]=g..a, SEG[7]=dp; dp is always off (1).
REQ-008 AN  output  8  active-low digit enables; one-hot-low or all ones.
REQ-009 frame_done  output  1  one-cycle pulse at each digit-7-to-0 wrap.

Function
REQ-010 Registers: divider count div (0..SCAN_DIV-1), digit index idx (3 bits), shadow (32), disp (32), pending (1).
REQ-011 div increments every cycle and reaches terminal count (tc) at SCAN_DIV-1.
REQ-012 At tc, div returns to 0 and idx advances by 1 modulo 8.
REQ-013 Loading shadow:
- load=1: shadow <= data and pending <= 1.
- load=0: shadow and pending hold.
REQ-014 Frame boundary = tc with idx==7.
- disp <= shadow (pre-edge value) if pending=1, then pending <= 0.
- disp is never written at any other time, so the display never tears mid-frame.
REQ-015 Load coincident with frame boundary:
- disp takes the old shadow.
- shadow takes the new data.
- pending ends at 1, so the new value shows on the next frame.
REQ-016 frame_done is registered and equals 1 on the cycle after each frame-boundary edge, 0 otherwise.
REQ-017 Hex decode of disp nibble[idx], as SEG values in hex:
- 0=C0, 1=F9, 2=A4, 3=B0
- 4=99, 5=92, 6=82, 7=F8
- 8=80, 9=90, A=88, b=83
- C=C6, d=A1, E=86, F=8E
REQ-018 Digit idx>0 is blank when blank_lz=1 and disp nibbles idx..7 are all zero.
- Digit 0 is never blanked, so value 0 shows a single "0".
REQ-019 Lit digit outputs: AN = ~(1<<idx), SEG = decode.
REQ-020 Blank digit outputs: AN=FF, SEG=FF.
REQ-021 SEG and AN are registered from the current idx and disp, so they lag an idx change by exactly one cycle.
REQ-022 blank_lz is sampled combinationally each cycle with no latching, so a change takes effect on the next output update.
REQ-023 An outside-range SCAN_DIV is a configuration error and has no defined behaviour.

Reset
REQ-024 On a clk edge with clr=1, everything below is forced; no other register updates on that edge:
- div=0, idx=0, shadow=0, disp=0, pending=0.
- SEG=FF, AN=FF, frame_done=0.
REQ-025 Reset takes precedence over load and tc on the same edge.
REQ-026 Reset mid-frame discards pending data.
REQ-027 First cycle after clr falls: AN=FE, SEG=C0 (digit 0 shows "0", any blank_lz).

Verification (SCAN_DIV=4 in simulation)
REQ-028 Reset then idle.
- AN sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, repeating.
- SEG=C0 throughout with blank_lz=0.
- frame_done pulses every 32 cycles.
REQ-029 Load 0x89ABCDEF one cycle at idx=2.
- Display unchanged until the frame boundary.
- Next frame digits 0..7 show SEG 8E,86,A1,C6,83,88,90,80.
- pending clears at the boundary.
REQ-030 blank_lz=1 with disp=0x00000A05.
- Digits 0..2 lit with SEG 92,C0,88.
- Digits 3..7 give AN=FF, SEG=FF.
REQ-031 Load 0x11111111 exactly on the frame-boundary edge while pending holds 0x22222222.
- Next frame shows all "2" (SEG A4).
- The frame after shows all "1" (SEG F9).
REQ-032 clr asserted mid-frame with pending set.
- Next cycle: SEG=FF, AN=FF.
- Then digit 0 shows C0.
- The pending value is never displayed.
